card_reader: RTL and testbench
==============================

# card_reader

Upstream front end of the turnstile controller: it receives the serial frame from the card contact interface, checks it, and presents the result as the `flag` / `a` pair that the turnstile FSM samples on its 400-cycle ticks. The block synchronises the raw card lines, debounces card insertion, deserialises a 12-bit frame, and validates its type and checksum. It holds `flag` and the 4-bit balance steady long enough for the downstream FSM to step through its card-read states.

## Interface
- `DEB_CYCLES`, default 16: consecutive cycles `card_present` must stay high before reception starts.
- `TIMEOUT`, default 2000: maximum cycles between accepted strobes in RECEIVE.
- `HOLD_CYCLES`, default 1000: minimum cycles `flag` stays high after a valid frame.
- `ERR_CYCLES`, default 500: cycles `err` stays high after a rejected frame.
- `CARD_TYPE`, default 4'h1: the only accepted card type code.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `card_present` in 1: card in slot, asynchronous level.
- `card_strobe` in 1: bit-valid strobe, asynchronous.
- `card_bit` in 1: serial data, asynchronous, LSB first.
- `flag` out 1: valid card accepted; feeds the turnstile `flag`.
- `a` out 4: balance of the last accepted card; feeds the turnstile `a`.
- `err` out 1: frame rejected.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Inputs `card_present`, `card_strobe` and `card_bit` each pass through 2-FF synchronisers (suffix `_s`).
- A strobe is accepted on the first cycle `card_strobe_s` is high after having been low. `card_bit_s` is sampled in that same cycle.
- Frame format, 12 bits, LSB first:
  - bits [3:0]: balance
  - bits [7:4]: type
  - bits [11:8]: checksum, equal to balance ^ type ^ 4'hA
- Single cycle counter, 12 bits wide, saturating at all ones. Bit counter, 4 bits wide.

States:
- IDLE: go to DEBOUNCE when `card_present_s` = 1.
- DEBOUNCE: counts cycles while `card_present_s` = 1. Any 0 returns the block to IDLE. Reaching DEB_CYCLES moves to RECEIVE, clearing the bit counter and the cycle counter.
- RECEIVE:
  - Each accepted strobe shifts a bit into the shift register and clears the cycle counter.
  - After the 12th bit, go to CHECK.
  - If the cycle counter reaches TIMEOUT, go to ERROR.
  - If `card_present_s` = 0, return to IDLE, discard the frame, and leave `err` low.
- CHECK, one cycle:
  - Type equal to CARD_TYPE and checksum correct: load `a` with the balance and go to VALID.
  - Otherwise go to ERROR.
- VALID:
  - `flag` = 1; strobes are ignored.
  - Exit to IDLE only when the cycle count has reached HOLD_CYCLES and `card_present_s` = 0.
  - A card still inserted keeps `flag` high indefinitely.
- ERROR:
  - `err` = 1 for ERR_CYCLES cycles, then low.
  - Return to IDLE only after `err` has dropped and `card_present_s` = 0, so one insertion produces at most one read attempt.

Other rules:
- `a` keeps the last accepted balance through IDLE, ERROR and later insertions. It changes only at CHECK success or reset. This keeps `a` stable through the turnstile's Balance_out phase after `flag` drops.
- Reset values: `flag` 0, `a` 4'h0, `err` 0, `busy` 0, state IDLE, shift register 0, counters 0, synchronisers 0.

## Timing
- Pin-to-internal latency is 2 cycles for every input.
- External requirements on the card interface:
  - `card_bit` stable from at least 3 cycles before the strobe rises until at least 1 cycle after.
  - Strobe high for at least 2 cycles and low for at least 2 cycles.
- The 12th accepted strobe moves the block to CHECK on the next edge. `flag` and the new `a` appear on the edge after that: 2 cycles after the 12th accepted strobe.
- `flag` is high for at least HOLD_CYCLES cycles, which exceeds the turnstile's two 400-cycle sampling ticks.
- Reset asserted in any state forces all outputs to their reset values immediately, without waiting for a clock edge. After release, the block starts in IDLE, and a card already present is debounced afresh.
- A strobe in the same cycle as `card_present_s` falling in RECEIVE: removal wins, and the bit is discarded.
- A TIMEOUT reached in the same cycle as an accepted strobe: the strobe wins, and the cycle counter clears.

## Test plan
- Valid frame: insert card, then send bits 1,1,1,0, 1,0,0,0, 0,0,1,1 (balance 7, type 1, checksum 4'hC) -> `flag` rises 2 cycles after the last accepted strobe, `a` = 4'h7. `flag` stays high for 1000 cycles, then drops once the card is removed; `err` stays 0.
- Bad checksum (balance 7, type 1, checksum 4'h0) -> `err` high for exactly 500 cycles, `flag` stays 0, `a` keeps its prior value. No new attempt is made until the card is removed and reinserted.
- Wrong type (balance 7, type 2, checksum 4'hF) -> rejected with `err`, `flag` 0.
- Timeout: 5 bits, then no strobes -> `err` rises 2000 cycles after the 5th accepted strobe.
- Removal during RECEIVE after 6 bits -> block returns to IDLE, `err` 0, `flag` 0. A subsequent valid insertion is accepted normally.
- Bounce and reset:
  - `card_present` toggling with a 10-cycle period -> `busy` toggles but RECEIVE is never entered.
  - Reset asserted during VALID -> `flag` 0, `a` 4'h0 immediately.

Source files
------------

// File: rtl/card_reader.sv
// Card contact front end: synchronises the card lines, debounces insertion,
// deserialises a 12-bit LSB-first frame and presents flag/a to the turnstile FSM.
module card_reader #(
    parameter int         DEB_CYCLES  = 16,
    parameter int         TIMEOUT     = 2000,
    parameter int         HOLD_CYCLES = 1000,
    parameter int         ERR_CYCLES  = 500,
    parameter logic [3:0] CARD_TYPE   = 4'h1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       card_present,
    input  logic       card_strobe,
    input  logic       card_bit,
    output logic       flag,
    output logic [3:0] a,
    output logic       err,
    output logic       busy
);
    localparam logic [11:0] DEB_M1 = 12'(DEB_CYCLES - 1);
    localparam logic [11:0] TO_M1  = 12'(TIMEOUT - 1);
    localparam logic [11:0] HOLD_C = 12'(HOLD_CYCLES);
    localparam logic [11:0] ERR_C  = 12'(ERR_CYCLES);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, RECEIVE, CHECK, VALID, ERROR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  present_sync_q, strobe_sync_q, bit_sync_q;
    logic        stb_prev_q;
    logic [11:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [11:0] sr_q, sr_d;
    logic [3:0]  a_q, a_d;
    logic        card_present_s, card_strobe_s, card_bit_s, stb_acc, frame_ok;

    assign card_present_s = present_sync_q[1];
    assign card_strobe_s  = strobe_sync_q[1];
    assign card_bit_s     = bit_sync_q[1];
    assign stb_acc        = card_strobe_s & ~stb_prev_q;
    assign cnt_inc        = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    assign frame_ok       = (sr_q[7:4] == CARD_TYPE) &&
                            (sr_q[11:8] == (sr_q[3:0] ^ sr_q[7:4] ^ 4'hA));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            present_sync_q <= '0;
            strobe_sync_q  <= '0;
            bit_sync_q     <= '0;
            stb_prev_q     <= 1'b0;
            cnt_q          <= '0;
            bitcnt_q       <= '0;
            sr_q           <= '0;
            a_q            <= '0;
        end else begin
            state_q        <= state_d;
            present_sync_q <= {present_sync_q[0], card_present};
            strobe_sync_q  <= {strobe_sync_q[0], card_strobe};
            bit_sync_q     <= {bit_sync_q[0], card_bit};
            stb_prev_q     <= card_strobe_s;
            cnt_q          <= cnt_d;
            bitcnt_q       <= bitcnt_d;
            sr_q           <= sr_d;
            a_q            <= a_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        a_d      = a_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (card_present_s) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!card_present_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_M1) begin
                    state_d  = RECEIVE;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                end
            end
            RECEIVE: begin
                // Removal beats a coincident strobe; a strobe beats a coincident timeout.
                if (!card_present_s) begin
                    state_d = IDLE;
                end else if (stb_acc) begin
                    sr_d     = {card_bit_s, sr_q[11:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    cnt_d    = '0;
                    if (bitcnt_q == 4'd11) state_d = CHECK;
                end else if (cnt_q == TO_M1) begin
                    state_d = ERROR;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (frame_ok) begin
                    a_d     = sr_q[3:0];
                    state_d = VALID;
                end else begin
                    state_d = ERROR;
                end
            end
            VALID: begin
                if (cnt_q >= HOLD_C && !card_present_s) state_d = IDLE;
            end
            ERROR: begin
                if (cnt_q >= ERR_C && !card_present_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flag = (state_q == VALID);
    assign err  = (state_q == ERROR) && (cnt_q < ERR_C);
    assign busy = (state_q != IDLE);
    assign a    = a_q;
endmodule

// File: tb/tb_card_reader.sv
// Directed bench for card_reader: valid/invalid frames, timeout, removal,
// insertion bounce and asynchronous reset.
module tb_card_reader;
    logic       clk = 1'b0;
    logic       reset, card_present, card_strobe, card_bit;
    logic       flag, err, busy;
    logic [3:0] a;
    int n_chk = 0, n_pass = 0;
    int errcnt = 0, flagcnt = 0;

    card_reader dut (
        .clk(clk), .reset(reset), .card_present(card_present),
        .card_strobe(card_strobe), .card_bit(card_bit),
        .flag(flag), .a(a), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err)  errcnt  <= errcnt + 1;
        if (flag) flagcnt <= flagcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic insert_card();
        card_present = 1'b1;
        cyc(30);
    endtask

    task automatic remove_card();
        card_present = 1'b0;
        cyc(8);
    endtask

    task automatic send_bit(input logic b);
        card_bit = b;
        cyc(3);
        card_strobe = 1'b1;
        cyc(3);
        card_strobe = 1'b0;
        cyc(3);
    endtask

    task automatic send_frame(input logic [11:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    initial begin
        int e0, f0, lat, run, maxrun, seen;
        logic [11:0] vf;
        reset = 1'b1; card_present = 1'b0; card_strobe = 1'b0; card_bit = 1'b0;
        cyc(3);
        chk("rst_flag", flag, 0);
        chk("rst_a", a, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc(2);

        // Valid frame: balance 7, type 1, checksum C; exact flag latency
        e0 = errcnt;
        vf = 12'hC17;
        insert_card();
        chk("deb_busy", busy, 1);
        send_frame(vf, 11);
        card_bit = vf[11];
        cyc(3);
        card_strobe = 1'b1;
        cyc(3);
        chk("valid_flag_check_cycle", flag, 0);
        cyc(1);
        chk("valid_flag_rise", flag, 1);
        chk("valid_a", a, 4'h7);
        card_strobe = 1'b0;
        card_present = 1'b0;
        cyc(995);
        chk("valid_hold", flag, 1);
        cyc(10);
        chk("valid_drop", flag, 0);
        chk("valid_busy", busy, 0);
        chk("valid_a_kept", a, 4'h7);
        chk("valid_no_err", errcnt - e0, 0);

        // Bad checksum: err exactly 500 cycles, no retry while card stays in
        e0 = errcnt; f0 = flagcnt;
        insert_card();
        send_frame(12'h017, 12);
        chk("badck_err", err, 1);
        cyc(600);
        chk("badck_err_low", err, 0);
        chk("badck_err_width", errcnt - e0, 500);
        chk("badck_no_flag", flagcnt - f0, 0);
        chk("badck_busy_held", busy, 1);
        chk("badck_a_kept", a, 4'h7);
        remove_card();
        chk("badck_idle", busy, 0);

        // Wrong type
        f0 = flagcnt;
        insert_card();
        send_frame(12'hF27, 12);
        chk("type_err", err, 1);
        chk("type_flag", flag, 0);
        cyc(600);
        remove_card();
        chk("type_no_flag", flagcnt - f0, 0);
        chk("type_a_kept", a, 4'h7);
        chk("type_idle", busy, 0);

        // Timeout after 5 bits; lat counts cycles from the 5th strobe pin edge
        insert_card();
        send_frame(12'hC17, 5);
        lat = 6;
        while (!err && lat < 2100) begin
            cyc(1);
            lat++;
        end
        chk("timeout_err", err, 1);
        chk("timeout_latency_ok", (lat >= 1998 && lat <= 2006), 1);
        card_present = 1'b0;
        cyc(600);
        chk("timeout_idle", busy, 0);

        // Removal mid-frame, then a fresh valid card (balance 9)
        e0 = errcnt; f0 = flagcnt;
        insert_card();
        send_frame(12'hC17, 6);
        remove_card();
        chk("remove_idle", busy, 0);
        chk("remove_no_err", errcnt - e0, 0);
        chk("remove_no_flag", flagcnt - f0, 0);
        insert_card();
        send_frame(12'h219, 12);
        chk("reins_flag", flag, 1);
        chk("reins_a", a, 4'h9);
        cyc(1200);
        chk("reins_held_inserted", flag, 1);
        remove_card();
        chk("reins_drop", flag, 0);
        chk("reins_a_kept", a, 4'h9);

        // Bouncing insertion never stays busy long enough to reach RECEIVE
        run = 0; maxrun = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            card_present = ((i % 10) < 5);
            cyc(1);
            if (busy) begin
                run++;
                seen = 1;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("bounce_busy_seen", seen, 1);
        chk("bounce_short_busy", (maxrun <= 8), 1);
        remove_card();
        chk("bounce_idle", busy, 0);

        // Asynchronous reset during VALID
        insert_card();
        send_frame(12'hC17, 12);
        chk("rstv_flag_before", flag, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstv_flag", flag, 0);
        chk("rstv_a", a, 4'h0);
        chk("rstv_busy", busy, 0);
        chk("rstv_err", err, 0);
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("rstv_redebounce", busy, 1);
        chk("rstv_flag_after", flag, 0);
        card_present = 1'b0;
        cyc(30);
        chk("rstv_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
